// File: rtl/minirisc_stack_engine.sv
// minirisc_stack_engine
//
// Call/interrupt stack for the MiniRISC CPU family. A push saves one frame into data memory
// through the CPU master bus, and a pop restores it. A frame is the PC, split into one or two
// bus words with the least-significant word first, followed by one word of flags. The stack
// grows downward from STACK_BASE, and sp always names the next free address. Frame depth is
// tracked so that a push on a full stack or a pop on an empty stack is rejected without any
// bus activity.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   op_start, op_push   start request (IDLE only), 1 = push / 0 = pop
//   flush               in IDLE: empty the stack (wins over op_start)
//   pc_in, flags_in     frame to push, captured with op_start
//   pc_out, flags_out   last popped frame
//   busy                high outside IDLE
//   op_done, op_error   completion pulse, error flags a rejected operation
//   sp, depth           next free address, current frame count
//   full, empty         depth == STACK_DEPTH, depth == 0
//   bus_req, bus_grant  master bus handshake, one word per granted cycle
//   bus_addr, bus_wr, bus_rd, bus_wdata  bus command, all zero unless granted
//   bus_rdata           read data, valid in the same cycle as bus_rd
module minirisc_stack_engine #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PC_W        = 8,
    parameter int unsigned FLAG_W      = 6,
    parameter int unsigned STACK_BASE  = (1 << ADDR_W) - 1,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             op_start,
    input  logic                             op_push,
    input  logic                             flush,
    input  logic [PC_W-1:0]                  pc_in,
    input  logic [FLAG_W-1:0]                flags_in,
    output logic [PC_W-1:0]                  pc_out,
    output logic [FLAG_W-1:0]                flags_out,
    output logic                             busy,
    output logic                             op_done,
    output logic                             op_error,
    output logic [ADDR_W-1:0]                sp,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             full,
    output logic                             empty,
    output logic                             bus_req,
    input  logic                             bus_grant,
    output logic [ADDR_W-1:0]                bus_addr,
    output logic                             bus_wr,
    output logic                             bus_rd,
    output logic [DATA_W-1:0]                bus_wdata,
    input  logic [DATA_W-1:0]                bus_rdata
);

    localparam int unsigned PC_BYTES   = (PC_W + DATA_W - 1) / DATA_W;
    localparam int unsigned FRAME      = PC_BYTES + 1;
    localparam int unsigned FRAME_BITS = FRAME * DATA_W;
    localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned K_W        = $clog2(FRAME);

    if (PC_W == 0 || PC_W > 2 * DATA_W) begin : g_bad_pc_w
        $error("minirisc_stack_engine: PC_W must be in 1..2*DATA_W");
    end
    if (FLAG_W == 0 || FLAG_W > DATA_W) begin : g_bad_flag_w
        $error("minirisc_stack_engine: FLAG_W must be in 1..DATA_W");
    end
    if (longint'(STACK_BASE) + 1 < longint'(STACK_DEPTH) * longint'(FRAME)) begin : g_bad_geom
        $error("minirisc_stack_engine: STACK_BASE+1 must be >= STACK_DEPTH*FRAME");
    end

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDone
    } state_e;

    state_e                  state_q;
    logic                    push_q;
    logic [K_W-1:0]          k_q;
    logic [ADDR_W-1:0]       ptr_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic [ADDR_W-1:0]       sp_q;
    logic [DEPTH_W-1:0]      depth_q;
    logic [PC_W-1:0]         pc_q;
    logic [FLAG_W-1:0]       flags_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic                    req_q;

    logic [FRAME_BITS-1:0]   push_image;
    logic [FRAME_BITS-1:0]   frame_next;
    logic                    xfer_go;
    logic                    is_full;
    logic                    is_empty;
    logic                    last_byte;

    assign is_full   = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign is_empty  = (depth_q == '0);
    assign last_byte = (k_q == K_W'(FRAME - 1));

    // frame_q doubles as the push shift-out register and the pop shadow register. A push
    // shifts words out at the bottom (PC LSB first, flags last). A pop shifts words in at
    // the bottom, so the flags word read first ends on top and the PC LSB read last ends at
    // the bottom, which is exactly the push image layout.
    always_comb begin
        push_image = '0;
        push_image[PC_W-1:0] = pc_in;
        push_image[PC_BYTES*DATA_W +: FLAG_W] = flags_in;

        if (push_q) begin
            frame_next = frame_q >> DATA_W;
        end else begin
            frame_next = {frame_q[FRAME_BITS-DATA_W-1:0], bus_rdata};
        end

        xfer_go   = (state_q == StXfer) && bus_grant;
        bus_addr  = xfer_go ? ptr_q : '0;
        bus_wr    = xfer_go && push_q;
        bus_rd    = xfer_go && !push_q;
        bus_wdata = (xfer_go && push_q) ? frame_q[DATA_W-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            push_q  <= 1'b0;
            k_q     <= '0;
            ptr_q   <= '0;
            frame_q <= '0;
            sp_q    <= ADDR_W'(STACK_BASE);
            depth_q <= '0;
            pc_q    <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        sp_q    <= ADDR_W'(STACK_BASE);
                        depth_q <= '0;
                    end else if (op_start) begin
                        busy_q <= 1'b1;
                        push_q <= op_push;
                        k_q    <= '0;
                        if (op_push ? is_full : is_empty) begin
                            // Rejected: report straight away, memory and sp untouched.
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= StXfer;
                            req_q   <= 1'b1;
                            frame_q <= push_image;
                            ptr_q   <= op_push ? sp_q : sp_q + ADDR_W'(1);
                        end
                    end
                end
                StXfer: begin
                    if (bus_grant) begin
                        frame_q <= frame_next;
                        k_q     <= k_q + K_W'(1);
                        ptr_q   <= push_q ? ptr_q - ADDR_W'(1) : ptr_q + ADDR_W'(1);
                        if (last_byte) begin
                            state_q <= StDone;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                            if (push_q) begin
                                sp_q    <= sp_q - ADDR_W'(FRAME);
                                depth_q <= depth_q + DEPTH_W'(1);
                            end else begin
                                sp_q    <= sp_q + ADDR_W'(FRAME);
                                depth_q <= depth_q - DEPTH_W'(1);
                                pc_q    <= frame_next[PC_W-1:0];
                                flags_q <= frame_next[PC_BYTES*DATA_W +: FLAG_W];
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out    = pc_q;
    assign flags_out = flags_q;
    assign busy      = busy_q;
    assign op_done   = done_q;
    assign op_error  = error_q;
    assign sp        = sp_q;
    assign depth     = depth_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign bus_req   = req_q;

endmodule
